// File: rtl/strobe_accum_pkg.sv
// Shared types and default widths for the strobe-sampled adder/accumulator.
package strobe_accum_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    ACC_ADD = 2'd2,
    ACC_SUB = 2'd3
  } mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 8;

endpackage

// File: rtl/strobe_gen.sv
// Programmable clock-enable divider: one strobe every div+1 enabled cycles.
module strobe_gen
  import strobe_accum_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  // >= rather than == so a live drop of div below the count fires at once
  assign w_hit  = (r_cnt >= div);
  assign strobe = ena & ~clr & w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/strobe_accum_adder.sv
// Sampled adder/accumulator with carry, valid pulse and sticky overflow.
// Define ADDER_SATURATE_EN to clamp results instead of wrapping.
module strobe_accum_adder
  import strobe_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             valid,
  output logic             overflow
);

`ifdef ADDER_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH:0] full,
                                                 input logic           is_sub);
    logic [WIDTH-1:0] res;
    res = full[WIDTH-1:0];
    if (full[WIDTH]) res = is_sub ? '0 : '1;
    return res;
  endfunction
`endif

  logic             w_strobe;
  mode_e            w_mode;
  logic             w_acc;
  logic             w_sub;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_res;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;
  logic             r_ovf;

  strobe_gen #(.DIV_W(DIV_W)) u_strobe_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .clr    (clr),
    .div    (div),
    .strobe (w_strobe)
  );

  // ACC modes feed the running sum back as the left operand and use a as the right
  always_comb begin
    w_mode = mode_e'(mode);
    w_acc  = (w_mode == ACC_ADD) || (w_mode == ACC_SUB);
    w_sub  = (w_mode == SUB) || (w_mode == ACC_SUB);
    w_x    = w_acc ? r_sum : a;
    w_y    = w_acc ? a : b;
    w_full = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
  end

`ifdef ADDER_SATURATE_EN
  assign w_res = sat_clamp(w_full, w_sub);
`else
  assign w_res = w_full[WIDTH-1:0];
`endif

  // Sample stage: results land one edge after the strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_strobe;
      if (w_strobe) begin
        r_sum   <= w_res;
        r_carry <= w_full[WIDTH];
        if (w_acc && w_full[WIDTH]) r_ovf <= 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign carry    = r_carry;
  assign valid    = r_valid;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_strobe_accum_adder.sv
// Directed and randomized bench for strobe_accum_adder against an integer reference model.
module tb_strobe_accum_adder;

  localparam int W    = 8;
  localparam int DW   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          clr;
  logic [DW-1:0] div;
  logic [1:0]    mode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  sum;
  logic          carry;
  logic          valid;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_cnt, m_sum;
  bit m_carry, m_valid, m_ovf;

  strobe_accum_adder #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clr      (clr),
    .div      (div),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .carry    (carry),
    .valid    (valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_carry = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Reference behaviour for one rising edge, from the current inputs
  task automatic model_edge();
    bit stb;
    int r;
    stb = ena && !clr && (m_cnt >= int'(div));
    if (clr) begin
      model_reset();
    end else begin
      m_valid = stb;
      if (ena) m_cnt = stb ? 0 : m_cnt + 1;
      if (stb) begin
        case (mode)
          2'd0:    r = int'(a) + int'(b);
          2'd1:    r = int'(a) - int'(b);
          2'd2:    r = m_sum + int'(a);
          default: r = m_sum - int'(a);
        endcase
        m_carry = (r > MAXV) || (r < 0);
`ifdef ADDER_SATURATE_EN
        if (r > MAXV) r = MAXV;
        if (r < 0) r = 0;
`else
        r = (r + MAXV + 1) % (MAXV + 1);
`endif
        m_sum = r;
        if (mode >= 2'd2 && m_carry) m_ovf = 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("sum",      32'(sum),      32'(m_sum));
    chk("carry",    32'(carry),    32'(m_carry));
    chk("valid",    32'(valid),    32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int v0, v1;
    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; div = '0; mode = 2'd0; a = '0; b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum",   32'(sum),      32'h0);
    chk("rst_carry", 32'(carry),    32'h0);
    chk("rst_valid", 32'(valid),    32'h0);
    chk("rst_ovf",   32'(overflow), 32'h0);
    rst_n = 1'b1;

    // ADD with div=1: strobe every second cycle
    ena = 1'b1; div = 8'd1; mode = 2'd0; a = 8'hFF; b = 8'h01;
    step();
    chk("add_nostrobe", 32'(valid), 32'h0);
    step();
    chk("add_valid", 32'(valid), 32'h1);
    chk("add_sum",   32'(sum),   32'h00);
    chk("add_carry", 32'(carry), 32'h1);
    chk("add_ovf",   32'(overflow), 32'h0);
    repeat (4) step();

    // SUB with borrow
    do_clr();
    mode = 2'd1; div = 8'd0; a = 8'h10; b = 8'h20;
    step();
`ifdef ADDER_SATURATE_EN
    chk("sub_sum", 32'(sum), 32'h00);
`else
    chk("sub_sum", 32'(sum), 32'hF0);
`endif
    chk("sub_carry", 32'(carry), 32'h1);

    // ACC_ADD sequence with overflow
    do_clr();
    mode = 2'd2; a = 8'h60;
    step();
    chk("acc1", 32'(sum), 32'h60);
    step();
    chk("acc2", 32'(sum), 32'hC0);
    chk("acc2_ovf", 32'(overflow), 32'h0);
    step();
`ifdef ADDER_SATURATE_EN
    chk("acc3", 32'(sum), 32'hFF);
`else
    chk("acc3", 32'(sum), 32'h20);
`endif
    chk("acc3_ovf", 32'(overflow), 32'h1);
    step();
`ifdef ADDER_SATURATE_EN
    chk("acc4", 32'(sum), 32'hFF);
`else
    chk("acc4", 32'(sum), 32'h80);
`endif
    chk("acc4_ovf", 32'(overflow), 32'h1);

    // div=5 with ena dropped for 3 cycles mid-count
    do_clr();
    mode = 2'd0; a = 8'h12; b = 8'h34; div = 8'd5;
    v0 = -1; v1 = -1;
    for (int i = 0; i < 20; i++) begin
      ena = !(i >= 8 && i <= 10);
      step();
      if (valid) begin
        if (v0 < 0) v0 = i;
        else if (v1 < 0) v1 = i;
      end
    end
    ena = 1'b1;
    chk("first_after_clr", 32'(v0), 32'd5);
    chk("ena_gap", 32'(v1 - v0), 32'd9);

    // clr coinciding with a strobe
    do_clr();
    mode = 2'd2; a = 8'h05; div = 8'd2;
    for (int i = 0; i < 8 && m_sum == 0; i++) step();
    for (int i = 0; i < 8 && m_cnt < 2; i++) step();
    chk("pre_clr_sum_nonzero", 32'(sum != 0), 32'h1);
    do_clr();
    chk("clr_valid", 32'(valid), 32'h0);
    chk("clr_sum",   32'(sum),   32'h0);
    chk("clr_ovf",   32'(overflow), 32'h0);
    step(); step();
    chk("clr_nostrobe", 32'(valid), 32'h0);
    step();
    chk("clr_next_strobe", 32'(valid), 32'h1);

    // live div reduction below the current count
    do_clr();
    mode = 2'd0; div = 8'd10;
    for (int i = 0; i < 20 && m_cnt != 7; i++) step();
    chk("cnt_at_7", 32'(m_cnt), 32'd7);
    div = 8'd2;
    step();
    chk("div_lower_strobe", 32'(valid), 32'h1);
    repeat (7) step();

    // asynchronous reset mid-count
    mode = 2'd2; a = 8'hA0; div = 8'd3;
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum",   32'(sum),      32'h0);
    chk("arst_carry", 32'(carry),    32'h0);
    chk("arst_valid", 32'(valid),    32'h0);
    chk("arst_ovf",   32'(overflow), 32'h0);
    model_reset();
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ena  = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      mode = 2'($urandom_range(0, 3));
      a    = 8'($urandom);
      b    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 4));
      step();
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
